// File: rtl/mif_sched.sv
// Command scheduler for the shared DDR MCB command port: arbitrates display reads
// against video writes and issues fixed-length bursts at linearly advancing frame addresses.
module mif_sched #(
    parameter int unsigned              ADDR_W        = 30,
    parameter int unsigned              BURST_LEN     = 32,
    parameter int unsigned              RD_FIFO_DEPTH = 64,
    parameter int unsigned              RD_LOW_WM     = 16,
    parameter int unsigned              FRAME_BURSTS  = 7500,
    parameter logic [ADDR_W-1:0]        RD_BASE       = '0,
    parameter logic [ADDR_W-1:0]        WR_BASE       = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              rd_vsync,
    input  logic              wr_vsync,
    input  logic              rd_pop,
    input  logic              wr_push,
    input  logic              cmd_full,
    output logic              cmd_en,
    output logic [2:0]        cmd_instr,
    output logic [5:0]        cmd_bl,
    output logic [ADDR_W-1:0] cmd_byte_addr,
    output logic              rd_frame_done,
    output logic              wr_frame_done,
    output logic              busy
);

    localparam int unsigned CW = $clog2(RD_FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FRAME_BURSTS + 1);

    localparam logic [CW-1:0]     DEPTH_C  = CW'(RD_FIFO_DEPTH);
    localparam logic [CW-1:0]     RD_BL_C  = CW'(BURST_LEN);
    localparam logic [CW-1:0]     URGENT_C = CW'(RD_FIFO_DEPTH - RD_LOW_WM);
    localparam logic [15:0]       WR_BL_C  = 16'(BURST_LEN);
    localparam logic [PW-1:0]     FRAME_C  = PW'(FRAME_BURSTS);
    localparam logic [ADDR_W-1:0] STRIDE_C = ADDR_W'(BURST_LEN * 8);

    typedef enum logic {IDLE, CMD} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      rd_credit;
    logic [15:0]        wr_avail;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic               last_wr;
    logic [2:0]         instr_q;
    logic [ADDR_W-1:0]  addr_q;

    logic               rd_elig;
    logic               wr_elig;
    logic               rd_urgent;
    logic               pick_rd;
    logic               launch;
    logic               issue_rd;
    logic               issue_wr;
    logic [CW:0]        credit_sum;
    logic [16:0]        avail_sum;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  wr_addr;

    always_comb begin
        rd_elig   = enable && !rd_frame_done && (rd_credit >= RD_BL_C);
        wr_elig   = enable && !wr_frame_done && (wr_avail >= WR_BL_C);
        rd_urgent = rd_elig && (rd_credit > URGENT_C);
        // Urgent reads pre-empt; otherwise last_wr alternates when both are ready.
        pick_rd   = rd_elig && (rd_urgent || !wr_elig || last_wr);
        launch    = (state == IDLE) && (rd_elig || wr_elig) && !cmd_full;
        issue_rd  = (state == CMD) && (instr_q == 3'b001);
        issue_wr  = (state == CMD) && (instr_q == 3'b000);
        rd_addr   = RD_BASE + ADDR_W'(rd_ptr) * STRIDE_C;
        wr_addr   = WR_BASE + ADDR_W'(wr_ptr) * STRIDE_C;
    end

    always_comb begin
        credit_sum = {1'b0, rd_credit} + (CW+1)'(rd_pop) - (issue_rd ? (CW+1)'(BURST_LEN) : '0);
        avail_sum  = {1'b0, wr_avail} + 17'(wr_push) - (issue_wr ? 17'(BURST_LEN) : 17'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = CMD;
            CMD:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_en        = (state == CMD);
        busy          = (state != IDLE);
        cmd_instr     = instr_q;
        cmd_byte_addr = addr_q;
        cmd_bl        = 6'(BURST_LEN - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= 3'b000;
            addr_q  <= '0;
        end else if (launch) begin
            instr_q <= pick_rd ? 3'b001 : 3'b000;
            addr_q  <= pick_rd ? rd_addr : wr_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_credit <= DEPTH_C;
            wr_avail  <= '0;
        end else begin
            rd_credit <= (credit_sum > {1'b0, DEPTH_C}) ? DEPTH_C : credit_sum[CW-1:0];
            wr_avail  <= avail_sum[16] ? 16'hFFFF : avail_sum[15:0];
        end
    end

    // A vsync on the issue cycle wins: the frame restarts and the increment is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            rd_frame_done <= 1'b1;
            wr_frame_done <= 1'b1;
            last_wr       <= 1'b1;
        end else begin
            if (issue_rd) begin
                last_wr <= 1'b0;
            end else if (issue_wr) begin
                last_wr <= 1'b1;
            end
            if (rd_vsync) begin
                rd_ptr        <= '0;
                rd_frame_done <= 1'b0;
            end else if (issue_rd) begin
                rd_ptr        <= rd_ptr + PW'(1);
                rd_frame_done <= (rd_ptr + PW'(1)) == FRAME_C;
            end
            if (wr_vsync) begin
                wr_ptr        <= '0;
                wr_frame_done <= 1'b0;
            end else if (issue_wr) begin
                wr_ptr        <= wr_ptr + PW'(1);
                wr_frame_done <= (wr_ptr + PW'(1)) == FRAME_C;
            end
        end
    end

endmodule

// File: tb/tb_mif_sched.sv
// Self-checking bench for mif_sched: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the scheduling rules.
module tb_mif_sched;

    localparam int          BL     = 32;
    localparam int          DEPTH  = 64;
    localparam int          LOW_WM = 16;
    localparam int          FB     = 4;
    localparam logic [31:0] RBASE  = 32'h1000;
    localparam logic [31:0] WBASE  = 32'h8000;

    logic        clk = 1'b0;
    logic        rst, enable, rd_vsync, wr_vsync, rd_pop, wr_push, cmd_full;
    logic        cmd_en, rd_frame_done, wr_frame_done, busy;
    logic [2:0]  cmd_instr;
    logic [5:0]  cmd_bl;
    logic [29:0] cmd_byte_addr;

    mif_sched #(
        .ADDR_W(30), .BURST_LEN(BL), .RD_FIFO_DEPTH(DEPTH), .RD_LOW_WM(LOW_WM),
        .FRAME_BURSTS(FB), .RD_BASE(30'h1000), .WR_BASE(30'h8000)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .rd_vsync(rd_vsync), .wr_vsync(wr_vsync),
        .rd_pop(rd_pop), .wr_push(wr_push), .cmd_full(cmd_full), .cmd_en(cmd_en),
        .cmd_instr(cmd_instr), .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr),
        .rd_frame_done(rd_frame_done), .wr_frame_done(wr_frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] addr;
    } cmd_rec_t;

    cmd_rec_t log_q[$];
    int       total = 0;
    int       bad   = 0;
    int       cyc   = 0;
    bit       en    = 1'b0;

    // Reference model: a command in flight, credit/space counts and frame positions.
    bit          m_inflight;
    bit          m_is_rd;
    logic [31:0] m_addr;
    int          m_credit, m_avail, m_rdptr, m_wrptr;
    bit          m_rddone, m_wrdone, m_lastwr;

    function automatic void modelReset();
        m_inflight = 0; m_is_rd = 0; m_addr = 0;
        m_credit = DEPTH; m_avail = 0; m_rdptr = 0; m_wrptr = 0;
        m_rddone = 1; m_wrdone = 1; m_lastwr = 1;
    endfunction

    function automatic void modelStep(bit s_rst, bit s_en, bit s_rv, bit s_wv,
                                      bit s_pop, bit s_push, bit s_full);
        bit did_rd, did_wr, next_inflight, re, we, take_rd;
        if (s_rst) begin
            modelReset();
            return;
        end
        did_rd = m_inflight && m_is_rd;
        did_wr = m_inflight && !m_is_rd;
        next_inflight = 0;
        if (!m_inflight) begin
            re = s_en && !m_rddone && m_credit >= BL;
            we = s_en && !m_wrdone && m_avail >= BL;
            if ((re || we) && !s_full) begin
                take_rd = re && ((m_credit > DEPTH - LOW_WM) || !we || m_lastwr);
                m_is_rd = take_rd;
                m_addr  = take_rd ? RBASE + 32'(m_rdptr * BL * 8) : WBASE + 32'(m_wrptr * BL * 8);
                m_addr  = m_addr & 32'h3FFF_FFFF;
                next_inflight = 1;
            end
        end
        m_credit = m_credit + int'(s_pop) - (did_rd ? BL : 0);
        if (m_credit > DEPTH) m_credit = DEPTH;
        m_avail = m_avail + int'(s_push) - (did_wr ? BL : 0);
        if (m_avail > 65535) m_avail = 65535;
        if (did_rd) begin m_rdptr++; m_rddone = (m_rdptr == FB); m_lastwr = 0; end
        if (did_wr) begin m_wrptr++; m_wrdone = (m_wrptr == FB); m_lastwr = 1; end
        if (s_rv) begin m_rdptr = 0; m_rddone = 0; end
        if (s_wv) begin m_wrptr = 0; m_wrdone = 0; end
        m_inflight = next_inflight;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkCycle();
        checkOutput("cmd_en",    32'(cmd_en),        32'(m_inflight));
        checkOutput("busy",      32'(busy),          32'(m_inflight));
        checkOutput("cmd_instr", 32'(cmd_instr),     m_is_rd ? 32'd1 : 32'd0);
        checkOutput("cmd_addr",  32'(cmd_byte_addr), m_addr);
        checkOutput("cmd_bl",    32'(cmd_bl),        32'(BL - 1));
        checkOutput("rd_done",   32'(rd_frame_done), 32'(m_rddone));
        checkOutput("wr_done",   32'(wr_frame_done), 32'(m_wrdone));
    endtask

    // Drive one cycle of inputs at the falling edge, check, log, advance the model.
    task automatic applyStimulus(input bit s_rst, input bit s_en, input bit s_rv, input bit s_wv,
                                 input bit s_pop, input bit s_push, input bit s_full);
        rst = s_rst; enable = s_en; rd_vsync = s_rv; wr_vsync = s_wv;
        rd_pop = s_pop; wr_push = s_push; cmd_full = s_full;
        checkCycle();
        if (cmd_en === 1'b1)
            log_q.push_back('{cyc, (cmd_instr == 3'b001), 32'(cmd_byte_addr)});
        modelStep(s_rst, s_en, s_rv, s_wv, s_pop, s_push, s_full);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit s_pop, input bit s_push);
        for (int i = 0; i < n; i++) applyStimulus(0, en, 0, 0, s_pop, s_push, 0);
    endtask

    task automatic checkLog(input int idx, input bit exp_rd, input logic [31:0] exp_addr, input string tag);
        if (idx < log_q.size()) begin
            checkOutput({tag, "_instr"}, 32'(log_q[idx].rd), 32'(exp_rd));
            checkOutput({tag, "_addr"}, log_q[idx].addr, exp_addr);
        end else begin
            checkOutput({tag, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        int  mark;
        bit  fired;
        bit  r_rst, r_en, r_rv, r_wv, r_pop, r_push, r_full;

        rst = 1; enable = 0; rd_vsync = 0; wr_vsync = 0; rd_pop = 0; wr_push = 0; cmd_full = 0;
        @(negedge clk);
        modelReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_cmd_en",  32'(cmd_en),        32'd0);
        checkOutput("reset_busy",    32'(busy),          32'd0);
        checkOutput("reset_rd_done", 32'(rd_frame_done), 32'd1);
        checkOutput("reset_wr_done", 32'(wr_frame_done), 32'd1);
        checkOutput("reset_addr",    32'(cmd_byte_addr), 32'd0);

        $display("[TB] read refill");
        en = 1; log_q.delete();
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        run(10, 0, 0);
        checkOutput("refill_count", 32'(log_q.size()), 32'd2);
        checkLog(0, 1, 32'h1000, "refill0");
        checkLog(1, 1, 32'h1100, "refill1");
        checkOutput("refill_bl", 32'(cmd_bl), 32'd31);
        run(32, 1, 0);
        run(4, 0, 0);
        checkLog(2, 1, 32'h1200, "refill2");

        $display("[TB] write gating");
        log_q.delete();
        applyStimulus(0, 1, 0, 1, 0, 0, 0);
        run(31, 0, 1);
        run(4, 0, 0);
        checkOutput("wgate_none", 32'(log_q.size()), 32'd0);
        mark = cyc;
        run(1, 0, 1);
        run(4, 0, 0);
        checkLog(0, 0, 32'h8000, "wgate");
        if (log_q.size() > 0) checkOutput("wgate_latency", 32'(log_q[0].cyc), 32'(mark + 2));

        $display("[TB] frame end and restart");
        log_q.delete();
        run(32, 1, 0);
        run(4, 0, 0);
        checkLog(0, 1, 32'h1300, "fend_last");
        checkOutput("fend_done", 32'(rd_frame_done), 32'd1);
        run(32, 1, 0);
        run(4, 0, 0);
        checkOutput("fend_blocked", 32'(log_q.size()), 32'd1);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        run(4, 0, 0);
        checkLog(1, 1, 32'h1000, "fend_restart");

        $display("[TB] arbitration");
        en = 0; log_q.delete();
        run(40, 1, 1);
        run(56, 0, 1);
        en = 1;
        run(12, 0, 0);
        checkOutput("rr_count", 32'(log_q.size()), 32'd4);
        checkLog(0, 0, 32'h8100, "rr0");
        checkLog(1, 1, 32'h1100, "rr1");
        checkLog(2, 0, 32'h8200, "rr2");
        checkLog(3, 0, 32'h8300, "rr3");

        log_q.delete(); en = 0;
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        run(56, 1, 0);
        en = 1;
        run(4, 0, 0);
        en = 0;
        run(32, 1, 1);
        en = 1;
        run(8, 0, 0);
        checkLog(0, 1, 32'h1200, "urg0");
        checkLog(1, 1, 32'h1300, "urg1");
        checkLog(2, 0, 32'h8000, "urg2");

        $display("[TB] backpressure");
        en = 0; log_q.delete();
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        run(32, 0, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0, 0, 1);
        checkOutput("bp_hold", 32'(log_q.size()), 32'd0);
        mark = cyc; en = 1;
        run(6, 0, 0);
        checkLog(0, 1, 32'h1000, "bp_first");
        if (log_q.size() > 0) checkOutput("bp_latency", 32'(log_q[0].cyc), 32'(mark + 1));
        checkLog(1, 0, 32'h8100, "bp_second");

        $display("[TB] vsync collision");
        en = 0;
        run(64, 1, 0);
        en = 1; log_q.delete(); fired = 0;
        for (int i = 0; i < 20; i++) begin
            r_rv = (cmd_en === 1'b1) && !fired;
            if (r_rv) fired = 1;
            applyStimulus(0, 1, r_rv, 0, 0, 0, 0);
        end
        checkLog(0, 1, 32'h1100, "coll0");
        checkLog(1, 1, 32'h1000, "coll1");

        $display("[TB] reset during command");
        run(32, 1, 0);
        fired = 0;
        for (int i = 0; i < 6; i++) begin
            r_rst = (cmd_en === 1'b1) && !fired;
            applyStimulus(r_rst, 1, 0, 0, 0, 0, 0);
            if (r_rst) begin
                fired = 1;
                checkOutput("rst_drop_cmd", 32'(cmd_en), 32'd0);
                checkOutput("rst_rd_done", 32'(rd_frame_done), 32'd1);
            end
        end
        checkOutput("rst_seen", 32'(fired), 32'd1);
        log_q.delete(); mark = cyc;
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        run(4, 0, 0);
        checkLog(0, 1, 32'h1000, "rst_restart");
        if (log_q.size() > 0) checkOutput("rst_restart_cyc", 32'(log_q[0].cyc), 32'(mark + 2));

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            r_rst  = ($urandom_range(0, 699) == 0);
            r_en   = ($urandom_range(0, 9) != 0);
            r_rv   = ($urandom_range(0, 59) == 0);
            r_wv   = ($urandom_range(0, 59) == 0);
            r_pop  = (m_credit < DEPTH) && ($urandom_range(0, 1) == 1);
            r_push = ($urandom_range(0, 1) == 1);
            r_full = ($urandom_range(0, 4) == 0);
            applyStimulus(r_rst, r_en, r_rv, r_wv, r_pop, r_push, r_full);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
